// File: rtl/core_bus_pkg.sv
// Shared types and default address map for the core bus arbiter.
package core_bus_pkg;

  typedef enum logic {
    HOST_INSTR = 1'b0,
    HOST_DATA  = 1'b1
  } host_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_RAM  = 2'd1,
    RSP_HW   = 2'd2,
    RSP_ERR  = 2'd3
  } rsp_kind_e;

  // we marks stores so the response can return zero read data
  typedef struct packed {
    host_e     host;
    rsp_kind_e kind;
    logic      we;
  } rsp_tag_t;

  localparam logic [31:0] DEF_RAM_BASE = 32'h0000_0000;
  localparam int unsigned DEF_RAM_SIZE = 262144;
  localparam logic [31:0] DEF_HW_BASE  = 32'hFF00_0000;
  localparam int unsigned DEF_HW_SIZE  = 65536;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
    return ((addr & ~(size - 32'd1)) == base);
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Host/target signal bundle; slave is the arbiter view, master the surrounding system.
interface core_bus_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        ram_req_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic        hw_req_o;
  logic        hw_we_o;
  logic [15:0] hw_addr_o;
  logic [31:0] hw_wdata_o;
  logic [31:0] hw_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i,
    output hw_req_o, hw_we_o, hw_addr_o, hw_wdata_o,
    input  hw_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i,
    input  hw_req_o, hw_we_o, hw_addr_o, hw_wdata_o,
    output hw_rdata_i
  );
endinterface

// File: rtl/core_bus_arbiter_addr_decode.sv
// Maps a granted address to the response kind; fetches may only target RAM.
module bus_addr_decode
  import core_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter int unsigned RAM_SIZE = DEF_RAM_SIZE,
  parameter logic [31:0] HW_BASE  = DEF_HW_BASE,
  parameter int unsigned HW_SIZE  = DEF_HW_SIZE
) (
  input  logic [31:0] addr_i,
  input  logic        is_fetch_i,
  output rsp_kind_e   kind_o
);

  // region compare, RAM takes precedence if the regions ever overlap
  always_comb begin
    kind_o = RSP_ERR;
    if (region_hit(addr_i, RAM_BASE, 32'(RAM_SIZE))) begin
      kind_o = RSP_RAM;
    end else if (region_hit(addr_i, HW_BASE, 32'(HW_SIZE)) && !is_fetch_i) begin
      kind_o = RSP_HW;
    end else begin
      kind_o = RSP_ERR;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Arbitrates ibex instruction/data ports onto one access slot per cycle and
// routes the fixed 1-cycle target response back to the granted host.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE        = DEF_RAM_BASE,
  parameter int unsigned RAM_SIZE        = DEF_RAM_SIZE,
  parameter logic [31:0] HW_BASE         = DEF_HW_BASE,
  parameter int unsigned HW_SIZE         = DEF_HW_SIZE,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic              clk,
  input logic              rst_n,
  core_bus_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  logic [3:0]  streak_q, streak_d;
  rsp_tag_t    tag_q, tag_d;
  logic        gnt_instr_s, gnt_data_s;
  logic [31:0] gnt_addr_s;
  rsp_kind_e   dec_kind_s;
  rsp_kind_e   kind_s;
  logic [31:0] rsp_rdata_s;

  // data wins unless it has starved a waiting fetch for MAX_STREAK grants
  always_comb begin
    gnt_data_s  = bus.data_req_i && !(bus.instr_req_i && (streak_q == MAX_STREAK));
    gnt_instr_s = bus.instr_req_i && !gnt_data_s;
    gnt_addr_s  = gnt_instr_s ? bus.instr_addr_i : bus.data_addr_i;
  end

  bus_addr_decode #(
    .RAM_BASE (RAM_BASE),
    .RAM_SIZE (RAM_SIZE),
    .HW_BASE  (HW_BASE),
    .HW_SIZE  (HW_SIZE)
  ) u_decode (
    .addr_i     (gnt_addr_s),
    .is_fetch_i (gnt_instr_s),
    .kind_o     (dec_kind_s)
  );

  // target request fan-out and next response tag
  always_comb begin
    if (gnt_instr_s || gnt_data_s) begin
      kind_s = dec_kind_s;
    end else begin
      kind_s = RSP_NONE;
    end
    bus.instr_gnt_o = gnt_instr_s;
    bus.data_gnt_o  = gnt_data_s;
    bus.ram_req_o   = (kind_s == RSP_RAM);
    bus.ram_we_o    = gnt_data_s && bus.data_we_i;
    bus.ram_be_o    = bus.data_be_i;
    bus.ram_addr_o  = gnt_addr_s;
    bus.ram_wdata_o = bus.data_wdata_i;
    bus.hw_req_o    = gnt_data_s && (kind_s == RSP_HW);
    bus.hw_we_o     = bus.data_we_i;
    bus.hw_addr_o   = gnt_addr_s[15:0];
    bus.hw_wdata_o  = bus.data_wdata_i;
    tag_d.host      = gnt_data_s ? HOST_DATA : HOST_INSTR;
    tag_d.kind      = kind_s;
    tag_d.we        = gnt_data_s && bus.data_we_i;
  end

  // streak counts data grants that overtook a waiting fetch
  always_comb begin
    if (gnt_instr_s || !bus.instr_req_i) begin
      streak_d = 4'd0;
    end else if (gnt_data_s && (streak_q < MAX_STREAK)) begin
      streak_d = streak_q + 4'd1;
    end else begin
      streak_d = streak_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
      tag_q    <= '{host: HOST_INSTR, kind: RSP_NONE, we: 1'b0};
    end else begin
      streak_q <= streak_d;
      tag_q    <= tag_d;
    end
  end

  // response steering; target read data is only valid in this cycle
  always_comb begin
    case (tag_q.kind)
      RSP_RAM: rsp_rdata_s = tag_q.we ? 32'd0 : bus.ram_rdata_i;
      RSP_HW:  rsp_rdata_s = tag_q.we ? 32'd0 : bus.hw_rdata_i;
      default: rsp_rdata_s = 32'd0;
    endcase
    if (tag_q.kind != RSP_NONE && tag_q.host == HOST_INSTR) begin
      bus.instr_rvalid_o = 1'b1;
      bus.instr_rdata_o  = rsp_rdata_s;
      bus.instr_err_o    = (tag_q.kind == RSP_ERR);
    end else begin
      bus.instr_rvalid_o = 1'b0;
      bus.instr_rdata_o  = 32'd0;
      bus.instr_err_o    = 1'b0;
    end
    if (tag_q.kind != RSP_NONE && tag_q.host == HOST_DATA) begin
      bus.data_rvalid_o = 1'b1;
      bus.data_rdata_o  = rsp_rdata_s;
      bus.data_err_o    = (tag_q.kind == RSP_ERR);
    end else begin
      bus.data_rvalid_o = 1'b0;
      bus.data_rdata_o  = 32'd0;
      bus.data_err_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: inputs change on negedge, outputs sampled before the next posedge.
module tb_core_bus_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  core_bus_arbiter_if bus ();

  core_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'd0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'd0;
    bus.data_wdata_i = 32'd0;
  endtask

  task automatic load(input logic [31:0] a);
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_be_i   = 4'hF;
    bus.data_addr_i = a;
  endtask

  initial begin
    logic [31:0] bnd_addr [4];
    logic        bnd_ram  [4];
    logic        bnd_hw   [4];
    logic        arb_seq  [6];
    vectors = 0;
    miscompares = 0;
    bus.ram_rdata_i = 32'hDEADBEEF;
    bus.hw_rdata_i  = 32'h1234_5678;
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_instr_rvalid", bus.instr_rvalid_o, 1'b0);
    check("rst_data_rvalid", bus.data_rvalid_o, 1'b0);
    check("rst_data_rdata", bus.data_rdata_o, 32'd0);
    check("rst_instr_err", bus.instr_err_o, 1'b0);
    check("rst_grants", {bus.instr_gnt_o, bus.data_gnt_o, bus.ram_req_o, bus.hw_req_o}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // plain RAM load
    @(negedge clk);
    load(32'h0000_0100);
    #1;
    check("ld_gnt", {bus.instr_gnt_o, bus.data_gnt_o}, 2'b01);
    check("ld_ram_req", bus.ram_req_o, 1'b1);
    check("ld_ram_we", bus.ram_we_o, 1'b0);
    check("ld_hw_req", bus.hw_req_o, 1'b0);
    check("ld_ram_addr", bus.ram_addr_o, 32'h0000_0100);
    @(negedge clk);
    idle();
    #1;
    check("ld_rvalid", bus.data_rvalid_o, 1'b1);
    check("ld_rdata", bus.data_rdata_o, 32'hDEADBEEF);
    check("ld_err", bus.data_err_o, 1'b0);
    check("ld_instr_rvalid", bus.instr_rvalid_o, 1'b0);
    @(negedge clk);
    #1;
    check("ld_rvalid_drop", bus.data_rvalid_o, 1'b0);

    // contention: data x4, then forced fetch, then data again (1 = data grant)
    arb_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0200;
      load(32'h0000_0300);
      #1;
      check($sformatf("arb_gnt_c%0d", c + 1), {bus.instr_gnt_o, bus.data_gnt_o},
            arb_seq[c] ? 2'b01 : 2'b10);
      check($sformatf("arb_irv_c%0d", c + 1), bus.instr_rvalid_o, (c == 5) ? 1'b1 : 1'b0);
      check($sformatf("arb_drv_c%0d", c + 1), bus.data_rvalid_o,
            (c >= 1 && c <= 4) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    idle();
    #1;
    check("arb_tail_drv", bus.data_rvalid_o, 1'b1);
    check("arb_tail_irv", bus.instr_rvalid_o, 1'b0);

    // fetch into HW region is a fault
    @(negedge clk);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'hFF00_0000;
    #1;
    check("fhw_gnt", bus.instr_gnt_o, 1'b1);
    check("fhw_reqs", {bus.ram_req_o, bus.hw_req_o}, 2'b00);
    @(negedge clk);
    idle();
    #1;
    check("fhw_rvalid", bus.instr_rvalid_o, 1'b1);
    check("fhw_err", bus.instr_err_o, 1'b1);
    check("fhw_rdata", bus.instr_rdata_o, 32'd0);
    check("fhw_data_rvalid", bus.data_rvalid_o, 1'b0);

    // HW store
    @(negedge clk);
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = 32'hFF00_0004;
    bus.data_wdata_i = 32'h0000_0041;
    #1;
    check("st_reqs", {bus.ram_req_o, bus.hw_req_o, bus.hw_we_o}, 3'b011);
    check("st_hw_addr", bus.hw_addr_o, 16'h0004);
    check("st_hw_wdata", bus.hw_wdata_o, 32'h0000_0041);
    @(negedge clk);
    idle();
    #1;
    check("st_rvalid", bus.data_rvalid_o, 1'b1);
    check("st_err", bus.data_err_o, 1'b0);
    check("st_rdata", bus.data_rdata_o, 32'd0);

    // unmapped load
    @(negedge clk);
    load(32'h8000_0000);
    #1;
    check("um_gnt", bus.data_gnt_o, 1'b1);
    check("um_reqs", {bus.ram_req_o, bus.hw_req_o}, 2'b00);
    check("um_addr_pass", bus.ram_addr_o, 32'h8000_0000);
    @(negedge clk);
    idle();
    #1;
    check("um_rvalid", bus.data_rvalid_o, 1'b1);
    check("um_err", bus.data_err_o, 1'b1);
    check("um_rdata", bus.data_rdata_o, 32'd0);

    // region edges, issued back to back
    bnd_addr = '{32'h0003_FFFC, 32'h0004_0000, 32'hFF00_FFFC, 32'hFF01_0000};
    bnd_ram  = '{1'b1, 1'b0, 1'b0, 1'b0};
    bnd_hw   = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load(bnd_addr[i]);
      #1;
      check($sformatf("bnd_reqs_%0d", i), {bus.ram_req_o, bus.hw_req_o}, {bnd_ram[i], bnd_hw[i]});
      if (i > 0) begin
        check($sformatf("bnd_err_%0d", i - 1), bus.data_err_o,
              !(bnd_ram[i - 1] || bnd_hw[i - 1]));
      end else begin
        check("bnd_rv_first", bus.data_rvalid_o, 1'b0);
      end
    end
    @(negedge clk);
    idle();
    #1;
    check("bnd_err_3", bus.data_err_o, 1'b1);
    check("bnd_rdata_3", bus.data_rdata_o, 32'd0);

    // reset while a load response is pending
    @(negedge clk);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0000_0400;
    load(32'h0000_0100);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("rm_rvalid_in_rst", bus.data_rvalid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rm_rvalid_rel", {bus.instr_rvalid_o, bus.data_rvalid_o}, 2'b00);
    @(negedge clk);
    #1;
    check("rm_rvalid_after", {bus.instr_rvalid_o, bus.data_rvalid_o}, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0200;
      load(32'h0000_0300);
      #1;
      check($sformatf("rm_arb_c%0d", c + 1), {bus.instr_gnt_o, bus.data_gnt_o},
            (c == 4) ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    idle();
    #1;
    check("rm_final_irv", bus.instr_rvalid_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
Sits between the ibex_core instruction/data ports and the two memory-mapped targets: the unified SRAM and the hardware register block. It arbitrates the two host ports onto one shared access slot per cycle and decodes the address into the RAM or HWREG region. It routes the fixed-latency target response back to the granted host and raises access faults for illegal or unmapped addresses. Data is prioritised, with a starvation limit that guarantees instruction fetch progress.

Parameters:
RAM_BASE, 32'h0000_0000, base of the SRAM region; aligned to RAM_SIZE.
RAM_SIZE, 262144, SRAM size in bytes; power of two.
HW_BASE, 32'hFF00_0000, base of the hardware register region.
HW_SIZE, 65536, HWREG region size in bytes; power of two.
MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request waits; range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant, combinational
instr_addr_i  in  32  fetch address
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch access fault, qualified by rvalid
data_req_i  in  1  load/store request
data_gnt_o  out  1  load/store grant, combinational
data_we_i  in  1  store enable
data_be_i  in  4  byte enables
data_addr_i  in  32  load/store address
data_wdata_i  in  32  store data
data_rvalid_o  out  1  load/store response valid
data_rdata_o  out  32  load data
data_err_o  out  1  load/store access fault, qualified by rvalid
ram_req_o  out  1  SRAM request
ram_we_o  out  1  SRAM write enable
ram_be_o  out  4  SRAM byte enables
ram_addr_o  out  32  SRAM address
ram_wdata_o  out  32  SRAM write data
ram_rdata_i  in  32  SRAM read data, valid 1 cycle after request
hw_req_o  out  1  HWREG request
hw_we_o  out  1  HWREG write enable
hw_addr_o  out  16  HWREG byte offset (data_addr_i[15:0])
hw_wdata_o  out  32  HWREG write data
hw_rdata_i  in  32  HWREG read data, valid 1 cycle after request

Behaviour:
- Reset values: all rvalid, err and rdata outputs are 0. The streak counter and the response tag are cleared. Grants and target requests are combinational and are 0 when no request is present.
- Targets are always ready and have a fixed 1-cycle read latency. At most one grant is issued per cycle.
- Grant rule:
  - Only one host requesting: grant it.
  - Both requesting: grant data unless streak == MAX_DATA_STREAK, in which case grant instr.
- Streak counter (4 bits):
  - Increments when data is granted while instr_req_i is high.
  - Clears when instr is granted or when instr_req_i is low.
  - Saturates at MAX_DATA_STREAK.
- Address decode of the granted address:
  - RAM hit when (addr & ~(RAM_SIZE-1)) == RAM_BASE.
  - HW hit when (addr & ~(HW_SIZE-1)) == HW_BASE.
  - Anything else is unmapped.
- Target requests:
  - ram_req_o = grant & RAM hit. ram_we_o = data grant & data_we_i.
  - hw_req_o = data grant & HW hit. hw_we_o = data_we_i.
  - A fetch to the HW region, or any unmapped access, issues no target request and is tagged as an error.
  - When the granted address selects no target, the target address/wdata buses carry the granted host's address and data_wdata_i unchanged.
- Response tag, registered on every grant: {host ∈ HOST_INSTR/HOST_DATA, kind ∈ RSP_NONE/RSP_RAM/RSP_HW/RSP_ERR}. RSP_NONE is used when nothing is granted.
- Response, exactly 1 cycle after grant:
  - The granted host's rvalid pulses for 1 cycle. Stores also receive rvalid.
  - rdata comes from ram_rdata_i or hw_rdata_i per the tag kind. rdata is 0 for RSP_ERR and for stores.
  - err = (kind == RSP_ERR).
  - The non-granted host's rvalid, err and rdata are 0.
- Back-to-back: a new grant in the response cycle is legal. The pipeline sustains 1 access/cycle.
- Reset mid-operation: the pending tag is cleared and no rvalid is emitted after reset deassertion.
- Misaligned addresses pass through unchanged; alignment is the core's responsibility.

Decomposition:
- Package core_bus_pkg: host_e {HOST_INSTR, HOST_DATA}, rsp_kind_e {RSP_NONE, RSP_RAM, RSP_HW, RSP_ERR}, rsp_tag_t struct, default address-map constants.
- Sub-module bus_addr_decode: combinational, addr + is_fetch -> rsp_kind_e. Instantiated once on the granted address.

Test Plan:
- Data load only from 0x0000_0100: data_gnt_o=1 same cycle, ram_req_o=1, ram_we_o=0 → next cycle data_rvalid_o=1, data_rdata_o equals ram_rdata_i (0xDEADBEEF), data_err_o=0.
- Simultaneous instr and data requests held for 6 cycles, MAX_DATA_STREAK=4 → grants D,D,D,D,I,D; instr_rvalid_o pulses exactly once, in cycle 6.
- Fetch from 0xFF00_0000 → instr_gnt_o=1, hw_req_o=0, ram_req_o=0; next cycle instr_rvalid_o=1, instr_err_o=1, instr_rdata_o=0.
- Data store to 0xFF00_0004, wdata 0x41, be 0xF → hw_req_o=1, hw_we_o=1, hw_addr_o=0x0004; next cycle data_rvalid_o=1, data_err_o=0.
- Data load from unmapped 0x8000_0000 → no target request; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
- Grant a load, assert rst_n=0 in the following cycle, then release → no rvalid on either port after release; the streak counter restarts at 0.
